// File: rtl/seq_divider_if.sv
// Handshake bundle for seq_divider: operand channel in, result channel out.
// The master modport is the requester side; the slave modport is the divider side.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, signed_mode, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  modport slave (
    input  in_valid, signed_mode, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, BPC quotient bits per RUN cycle, signed/unsigned.
// Zero divisor and signed MIN/-1 are answered straight from IDLE.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 2
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned N    = WIDTH / BPC;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem, rem_nx;
  logic [WIDTH-1:0] quo, quo_nx, dvs;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] q_r, r_r;
  logic             dz_r, ov_r;

  logic             accept, zero_div, ovf;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  assign accept   = bus.in_valid && (state == S_IDLE);
  assign zero_div = (bus.divisor == '0);
  assign ovf      = bus.signed_mode && (bus.dividend == MIN) && (bus.divisor == '1);
  assign a_neg    = bus.signed_mode && bus.dividend[WIDTH-1];
  assign b_neg    = bus.signed_mode && bus.divisor[WIDTH-1];
  // Magnitudes read as unsigned WIDTH bits, so |MIN| = 2^(WIDTH-1) is exact.
  assign a_mag    = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag    = b_neg ? -bus.divisor  : bus.divisor;

  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    for (int unsigned i = 0; i < BPC; i++) begin
      rem_nx = {rem_nx[WIDTH-1:0], quo_nx[WIDTH-1]};
      quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
      if (rem_nx >= {1'b0, dvs}) begin
        rem_nx    = rem_nx - {1'b0, dvs};
        quo_nx[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (zero_div || ovf) ? S_DONE : S_RUN;
      S_RUN:  if (cnt == LAST) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
      ov_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (zero_div) begin
              q_r  <= '1;
              r_r  <= bus.dividend;
              dz_r <= 1'b1;
              ov_r <= 1'b0;
            end else if (ovf) begin
              q_r  <= MIN;
              r_r  <= '0;
              dz_r <= 1'b0;
              ov_r <= 1'b1;
            end
          end
        end
        S_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        S_FIX: begin
          q_r  <= q_fix;
          r_r  <= r_fix;
          dz_r <= 1'b0;
          ov_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dz_r;
  assign bus.overflow    = ov_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks on a 32/2 divider, then a random sweep over WIDTH x BPC
// compared against an arithmetic reference.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sweep_go   = 1'b0;
  int sweep_done = 0;

  seq_divider_if #(.WIDTH(32)) d();
  seq_divider #(.WIDTH(32), .BPC(2)) u_dut (.clk(clk), .rst(rst), .bus(d));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input int w, input bit sm,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned q, output longint unsigned r,
                                  output bit dz, output bit ov);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned minv = 64'd1 << (w - 1);
    longint sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (!sm) begin
      q = a / b; r = a % b;
    end else if (a == minv && b == mask) begin
      q = minv; r = 0; ov = 1'b1;
    end else begin
      sa = (a & minv) != 0 ? longint'(a | ~mask) : longint'(a);
      sb = (b & minv) != 0 ? longint'(b | ~mask) : longint'(b);
      q  = longint'(sa / sb) & mask;
      r  = longint'(sa % sb) & mask;
    end
  endfunction

  task automatic do_op(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       input int stall,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat,
                       output logic post_ov, output logic post_ir);
    @(negedge clk);
    check("acc_rdy", d.in_ready, 1);
    d.in_valid    = 1'b1;
    d.signed_mode = sm;
    d.dividend    = a;
    d.divisor     = b;
    d.out_ready   = (stall == 0);
    @(posedge clk); #1;
    d.in_valid = 1'b0;
    d.dividend = $urandom;
    d.divisor  = $urandom;
    lat = 1;
    while (!d.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = d.quotient;
    r  = d.remainder;
    dz = d.div_by_zero;
    ov = d.overflow;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("bp_valid", d.out_valid, 1);
      check("bp_q", d.quotient, q);
      check("bp_r", d.remainder, r);
      if (i == 0) begin
        d.in_valid = 1'b1;
        d.dividend = 32'd5;
        d.divisor  = 32'd1;
      end else if (i == 1) begin
        check("bp_in_ready", d.in_ready, 0);
        d.in_valid = 1'b0;
      end
    end
    d.out_ready = 1'b1;
    @(posedge clk); #1;
    post_ov = d.out_valid;
    post_ir = d.in_ready;
  endtask

  typedef struct {
    logic        sm;
    logic [31:0] a, b, q, r;
    logic        dz, ov;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tv[7];
    logic [31:0] q, r;
    logic        dz, ov, pov, pir, seen;
    int          lat;

    d.in_valid = 1'b0; d.out_ready = 1'b1; d.signed_mode = 1'b0;
    d.dividend = '0;   d.divisor   = '0;
    #12;
    check("rst_q", d.quotient, 0);
    check("rst_r", d.remainder, 0);
    check("rst_flags", {d.div_by_zero, d.overflow}, 0);
    check("rst_ov_busy", {d.out_valid, d.busy}, 0);
    check("rst_in_ready", d.in_ready, 1);
    @(negedge clk); rst = 1'b0;

    tv[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 18};
    tv[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 18};
    tv[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 18};
    tv[3] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 1'b0, 18};
    tv[4] = '{1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1};
    tv[5] = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1'b0, 1};
    tv[6] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 1};
    foreach (tv[i]) begin
      do_op(tv[i].sm, tv[i].a, tv[i].b, 0, q, r, dz, ov, lat, pov, pir);
      check($sformatf("dir%0d_q", i), q, tv[i].q);
      check($sformatf("dir%0d_r", i), r, tv[i].r);
      check($sformatf("dir%0d_flags", i), {dz, ov}, {tv[i].dz, tv[i].ov});
      check($sformatf("dir%0d_lat", i), lat, tv[i].lat);
      check($sformatf("dir%0d_ov_1cyc", i), pov, 0);
      check($sformatf("dir%0d_ready_back", i), pir, 1);
    end

    do_op(1'b0, 32'd1000, 32'd10, 5, q, r, dz, ov, lat, pov, pir);
    check("bp_final_q", q, 100);
    check("bp_final_r", r, 0);
    check("bp_lat", lat, 18);
    check("bp_released", {pov, pir}, 2'b01);
    check("bp_q_after", d.quotient, 100);

    @(negedge clk);
    d.in_valid = 1'b1; d.signed_mode = 1'b0; d.dividend = 32'd1000; d.divisor = 32'd7;
    @(posedge clk); #1;
    d.in_valid = 1'b0;
    check("mid_busy", d.busy, 1);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", d.quotient, 0);
    check("mid_rst_r", d.remainder, 0);
    check("mid_rst_flags", {d.div_by_zero, d.overflow}, 0);
    check("mid_rst_state", {d.out_valid, d.busy, d.in_ready}, 3'b001);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      seen |= d.out_valid;
    end
    check("mid_no_result", seen, 0);
    do_op(1'b0, 32'd9, 32'd3, 0, q, r, dz, ov, lat, pov, pir);
    check("post_rst_q", q, 3);
    check("post_rst_r", r, 0);
    check("post_rst_lat", lat, 18);

    sweep_go = 1'b1;
    wait (sweep_done == 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar g = 0; g < 12; g++) begin : g_sw
    localparam int unsigned W = (g < 4) ? 8 : ((g < 8) ? 16 : 32);
    localparam int unsigned B = (g % 4 == 0) ? 1 : (g % 4 == 1) ? 2 : (g % 4 == 2) ? 4 : W;

    seq_divider_if #(.WIDTH(W)) s();
    seq_divider #(.WIDTH(W), .BPC(B)) u_dut (.clk(clk), .rst(rst), .bus(s));

    initial begin
      longint unsigned mask, a, b, eq, er;
      bit              sm, edz, eov;
      int              lat, elat, sel;
      string           tg;
      s.in_valid = 1'b0; s.out_ready = 1'b1; s.signed_mode = 1'b0;
      s.dividend = '0;   s.divisor   = '0;
      mask = (64'd1 << W) - 1;
      tg   = $sformatf("w%0db%0d", W, B);
      wait (sweep_go);
      for (int n = 0; n < 1000; n++) begin
        sm  = 1'($urandom_range(0, 1));
        a   = {$urandom, $urandom} & mask;
        sel = $urandom_range(0, 9);
        case (sel)
          0: b = 0;
          1: begin a = 64'd1 << (W - 1); b = mask; end
          2: b = $urandom_range(1, 7);
          3: b = ~{32'd0, $urandom_range(0, 6)} & mask;
          4: b = ({$urandom, $urandom} & mask) >> $urandom_range(1, W - 1);
          default: b = {$urandom, $urandom} & mask;
        endcase
        if ($urandom_range(0, 15) == 0) a = 0;
        ref_div(W, sm, a, b, eq, er, edz, eov);
        elat = (edz || eov) ? 1 : int'(W / B) + 2;

        @(negedge clk);
        s.in_valid    = 1'b1;
        s.signed_mode = sm;
        s.dividend    = a[W-1:0];
        s.divisor     = b[W-1:0];
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        s.dividend = W'($urandom);
        s.divisor  = W'($urandom);
        lat = 1;
        while (!s.out_valid && lat < int'(W) + 8) begin
          @(posedge clk); #1;
          lat++;
        end
        check({tg, "_q"}, s.quotient, eq);
        check({tg, "_r"}, s.remainder, er);
        check({tg, "_flags"}, {s.div_by_zero, s.overflow}, {edz, eov});
        check({tg, "_lat"}, lat, elat);
        @(posedge clk);
      end
      sweep_done++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
